// File: rtl/gf2m_add_acc.sv
// gf2m_add_acc: digit-serial GF(2^m) adder/accumulator; result = a ^ b or acc ^ a, DIGIT bits per clock.
// Define GF_ADD_ZERO_FLAG_EN to add the registered is_zero_o result flag.
module gf2m_add_acc #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o
`ifdef GF_ADD_ZERO_FLAG_EN
  ,
  output logic             is_zero_o
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  // Selects the low DIGIT bits; collapses to all ones when DIGIT == WIDTH.
  localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << DIGIT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   w_xor_s;
  logic [WIDTH-1:0]   w_rot_s;
  logic               last_s;
  logic               start_go_s;

  // One digit per cycle: XOR the low digit, then rotate so the next digit lands at the bottom.
  assign w_xor_s    = w_q ^ (s_q & LOW_MASK);
  assign w_rot_s    = (w_xor_s >> DIGIT) | (w_xor_s << (WIDTH - DIGIT));
  assign last_s     = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign start_go_s = (state_q == ST_IDLE) && start_i && !clear_i;

  // Next-state and datapath control; clear dominates both start and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    s_d     = s_q;
    acc_d   = acc_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
      acc_d   = {WIDTH{1'b0}};
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            w_d     = a_i;
            s_d     = mode_i ? acc_q : b_i;
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          w_d = w_rot_s;
          s_d = s_q >> DIGIT;
          if (last_s) begin
            out_d   = w_rot_s;
            acc_d   = w_rot_s;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      w_q     <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = out_q;

`ifdef GF_ADD_ZERO_FLAG_EN
  logic nz_q, nz_d;
  logic zf_q, zf_d;
  logic digit_nz_s;

  assign digit_nz_s = |w_xor_s[DIGIT-1:0];

  // Sticky non-zero bit folded per digit so completion needs only a single OR.
  always_comb begin
    nz_d = nz_q;
    zf_d = zf_q;
    if (start_go_s) begin
      nz_d = 1'b0;
    end else if ((state_q == ST_RUN) && !clear_i) begin
      nz_d = nz_q | digit_nz_s;
      if (last_s) begin
        zf_d = ~(nz_q | digit_nz_s);
      end else begin
        zf_d = zf_q;
      end
    end else begin
      nz_d = nz_q;
    end
  end

  // Zero-flag registers; only reset clears the flag, it otherwise tracks out_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      nz_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      nz_q <= nz_d;
      zf_q <= zf_d;
    end
  end

  assign is_zero_o = zf_q;
`endif

endmodule

// File: tb/tb_gf2m_add_acc.sv
// Self-checking bench for gf2m_add_acc: random operands against a behavioural XOR/accumulate model.
module tb_gf2m_add_acc;

  localparam int W = 256;
  localparam int D = 64;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         clear;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
`ifdef GF_ADD_ZERO_FLAG_EN
  logic         is_zero;
`endif

  gf2m_add_acc #(.WIDTH(W), .DIGIT(D)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .clear_i (clear),
    .mode_i  (mode),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .out_o   (out)
`ifdef GF_ADD_ZERO_FLAG_EN
    ,
    .is_zero_o (is_zero)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  // Reference model state: last result, running sum, zero flag of last result.
  logic [W-1:0] out_m;
  logic [W-1:0] acc_m;
  logic         zero_m;
  int           done_cyc = 0;
  int           prev_done_cyc = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
`ifdef GF_ADD_ZERO_FLAG_EN
    chk_bit(tag, is_zero, zero_m);
`endif
  endtask

  // Issue one operation and check the whole handshake; hold=1 keeps start high during RUN.
  task automatic run_op(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    logic [W-1:0] res;
    res   = m ? (acc_m ^ av) : (av ^ bv);
    mode  = m;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick;
    a     = rnd();
    b     = rnd();
    mode  = ~m;
    for (int i = 0; i < N; i++) begin
      chk_bit("busy_run", busy, 1'b1);
      chk_bit("done_run", done, 1'b0);
      start = hold && (i < N - 1);
      tick;
    end
    start = 1'b0;
    out_m  = res;
    acc_m  = res;
    zero_m = (res == '0);
    chk_bit("done_pulse", done, 1'b1);
    chk_bit("busy_end", busy, 1'b0);
    chk("out_result", out, out_m);
    chk_zero("is_zero");
    prev_done_cyc = done_cyc;
    done_cyc      = cyc;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    acc_m = '0;
    chk_bit("clr_busy", busy, 1'b0);
    chk_bit("clr_done", done, 1'b0);
    chk("clr_out", out, out_m);
  endtask

  initial begin
    logic [W-1:0] x;
    reset  = 1'b1;
    start  = 1'b0;
    clear  = 1'b0;
    mode   = 1'b0;
    a      = '0;
    b      = '0;
    out_m  = '0;
    acc_m  = '0;
    zero_m = 1'b0;
    #1;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk("rst_out", out, out_m);
    chk_zero("rst_is_zero");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick;

    // Load acc, then reset asynchronously while the 2nd digit is in flight.
    run_op(1'b1, rnd(), rnd(), 1'b0);
    mode  = 1'b0;
    a     = rnd();
    b     = rnd();
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    #2 reset = 1'b1;
    #1;
    out_m  = '0;
    acc_m  = '0;
    zero_m = 1'b0;
    chk_bit("amid_busy", busy, 1'b0);
    chk_bit("amid_done", done, 1'b0);
    chk("amid_out", out, out_m);
    chk_zero("amid_is_zero");
    @(negedge clk);
    reset = 1'b0;
    tick;
    x = rnd();
    run_op(1'b1, x, rnd(), 1'b0);
    chk("after_rst_acc0", out, x);

    // Plain A^B operations with idle gaps; done must last exactly one cycle.
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, rnd(), rnd(), 1'b0);
      tick;
      chk_bit("done_one_cycle", done, 1'b0);
    end

    // Clear then three back-to-back accumulations.
    do_clear;
    run_op(1'b1, rnd(), rnd(), 1'b0);
    run_op(1'b1, rnd(), rnd(), 1'b0);
    chk_i("done_spacing", done_cyc - prev_done_cyc, N + 1);
    run_op(1'b1, rnd(), rnd(), 1'b0);
    chk_i("done_spacing", done_cyc - prev_done_cyc, N + 1);

    // start held through RUN must not queue a second operation.
    tick;
    run_op(1'b0, rnd(), rnd(), 1'b1);
    tick;
    chk_bit("no_extra_done", done, 1'b0);
    chk_bit("no_extra_busy", busy, 1'b0);
    tick;
    chk_bit("no_extra_done2", done, 1'b0);

    // start together with clear in IDLE: clear wins.
    start = 1'b1;
    clear = 1'b1;
    mode  = 1'b1;
    a     = rnd();
    tick;
    start = 1'b0;
    clear = 1'b0;
    acc_m = '0;
    chk_bit("sc_busy", busy, 1'b0);
    chk_bit("sc_done", done, 1'b0);
    chk("sc_out", out, out_m);
    tick;
    chk_bit("sc_busy2", busy, 1'b0);
    chk_bit("sc_done2", done, 1'b0);
    x = rnd();
    run_op(1'b1, x, rnd(), 1'b0);
    chk("sc_acc0", out, x);

    // clear during the 3rd RUN cycle aborts with no done.
    tick;
    mode  = 1'b1;
    a     = rnd();
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    acc_m = '0;
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk("abort_out", out, out_m);
    for (int i = 0; i < N; i++) begin
      tick;
      chk_bit("abort_no_done", done, 1'b0);
    end
    x = rnd();
    run_op(1'b1, x, rnd(), 1'b0);
    chk("abort_acc0", out, x);

    // Zero result boundary and back to non-zero.
    run_op(1'b0, {W{1'b1}}, {W{1'b1}}, 1'b0);
    run_op(1'b0, {{(W-1){1'b0}}, 1'b1}, {W{1'b0}}, 1'b0);

    // Random mix of modes, clears and held start.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) do_clear;
      run_op(1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/gf2m_add_acc.md
# gf2m_add_acc

Digit-serial GF(2^m) adder/accumulator for the ECC datapath, a parametrised successor to the fixed 256-bit combinational XOR adder. It computes A^B, or accumulates A into an internal running sum (Acc ^= A), processing DIGIT bits per clock over WIDTH/DIGIT cycles. Sits between the field-multiplier outputs and the point-arithmetic register file. It gives a narrow, pipelined XOR datapath and multi-term field sums such as Σ partial products without external feedback wiring.

## Interface
Parameters:
- WIDTH, 256, field element width m (bits); must be an integer multiple of DIGIT
- DIGIT, 64, bits processed per cycle; N = WIDTH/DIGIT cycles per operation

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- clear  in  1  synchronous clear of accumulator and abort of any operation
- mode  in  1  0: result = a ^ b; 1: result = acc ^ a
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start (ignored when mode=1)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse, result valid on out
- out  out  WIDTH  last result, held until next done or clear
- is_zero  out  1  present only with GF_ADD_ZERO_FLAG_EN (see Configuration)

## Operation
- States: IDLE, RUN. A digit counter runs 0..N-1.
- IDLE, start=1, clear=0: latch a into work register W. Latch the second operand (b if mode=0, acc if mode=1) into S. Counter <= 0, go to RUN.
- RUN, each cycle:
  - Low digit of W is replaced with W[DIGIT-1:0] ^ S[DIGIT-1:0], then W is rotated right by DIGIT.
  - S is shifted right by DIGIT.
  - The counter increments.
- After N digits W is back in its original alignment and holds the full result.
- Completion, on the cycle the last digit is processed: out <= result, acc <= result (both modes), done pulses, go to IDLE.
- start while in RUN: ignored; no queuing.
- clear:
  - Takes priority over start and over completion.
  - Sets acc <= 0 and forces IDLE. No done is issued.
  - out is left unchanged.
- Arithmetic: bitwise XOR only, no carries. All registers are WIDTH bits and there is no overflow.
- mode=1 with acc=0 returns a. Chained mode=1 operations give the XOR of all the A operands since the last clear or reset.

## Timing
- Reset (asynchronous, any state, mid-operation included):
  - State IDLE, counter 0.
  - busy=0, done=0, out=0, acc=0, is_zero=0.
  - A partial operation is discarded.
- start captured at edge k:
  - busy=1 after edges k through k+N-1.
  - At edge k+N: out and acc updated, done=1 for exactly the following cycle, busy=0.
- Latency: N cycles from the start edge to the done edge (4 at defaults).
- Throughput: one operation per N+1 cycles. start may be asserted in the cycle done is high, because the state is already IDLE then.
- Simultaneous start and clear in IDLE: clear wins and start is dropped.
- DIGIT=WIDTH (N=1): one-cycle RUN with the same handshake.
- a and b only need to be stable at the start edge.

## Configuration
- GF_ADD_ZERO_FLAG_EN defined:
  - Adds output is_zero.
  - is_zero is registered at completion as (result == 0) and is held with out.
  - Cleared by reset only.
  - Reduction is done incrementally per digit, with no wide compare in the completion cycle.
- Not defined: port is_zero does not exist and there is no zero-detect logic.

## Test plan
Defaults WIDTH=256, DIGIT=64.
- reset asserted mid-RUN (2nd digit) -> busy, done, out, acc all 0 immediately. A following start completes in 4 cycles with the correct result.
- mode=0, a=256'h1234…(random A), b=random B, start at edge k -> done high after edge k+4 only, out = A^B, busy high for exactly 4 cycles.
- clear, then three mode=1 operations with a=A1, A2, A3, back-to-back (start in each done cycle) -> outs A1, A1^A2, A1^A2^A3. Done pulses spaced 5 cycles apart.
- start re-asserted during RUN, and start with clear in IDLE -> no extra done. In the start+clear case acc=0 and out is unchanged.
- With GF_ADD_ZERO_FLAG_EN, mode=0, a=b=256'hFFFF…FF -> out=0, is_zero=1. Then a=256'h1 with b=0 -> is_zero=0.
- clear asserted in the 3rd RUN cycle -> no done, out holds its previous value, acc=0, state IDLE next cycle.
